// File: rtl/mem_hex_dumper_pkg.sv
// Shared types, ASCII constants and helpers for the memory hex dumper.
// Optional line-address prefix is controlled by DUMPER_ADDR_PREFIX_EN.
package mem_dump_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_PFX  = 4'd1,
        ST_REQ  = 4'd2,
        ST_WAIT = 4'd3,
        ST_HI   = 4'd4,
        ST_LO   = 4'd5,
        ST_SEP  = 4'd6,
        ST_CR   = 4'd7,
        ST_LF   = 4'd8,
        ST_FIN  = 4'd9
    } state_e;

    localparam logic [7:0] SP    = 8'h20;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] COLON = 8'h3A;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        logic [7:0] res;
        if (nib < 4'd10) begin
            res = 8'h30 + {4'h0, nib};
        end else begin
            res = 8'h37 + {4'h0, nib};
        end
        return res;
    endfunction

    // States in which a character is offered on the byte stream.
    function automatic logic is_emit(input state_e st);
        logic res;
        case (st)
            ST_PFX, ST_HI, ST_LO, ST_SEP, ST_CR, ST_LF: res = 1'b1;
            default:                                    res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_hex_dumper_if.sv
// Memory read port plus ASCII byte stream used by the hex dumper.
// master = dumper side, slave = memory/UART side.
interface mem_hex_dumper_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/mem_hex_dumper_hex_nibble_mux.sv
// Picks one nibble either from the data byte (high/low) or from the
// line address (digit index counted from the most significant digit)
// and converts it to an uppercase ASCII hex character.
module hex_nibble_mux
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int NDIG   = 4,
    parameter int SEL_W  = 3
) (
    input  logic [7:0]        byte_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              use_addr,
    input  logic [SEL_W-1:0]  digit_sel,
    input  logic              lo_nib,
    output logic [7:0]        ascii
);

    localparam int PAD_W = NDIG * 4;

    logic [PAD_W-1:0] addr_pad_s;
    logic [3:0]       addr_nib_s;
    logic [3:0]       nib_s;

    assign addr_pad_s = PAD_W'(addr_in);

    // Select the addressed hex digit of the line address.
    always_comb begin
        addr_nib_s = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            addr_nib_s = (digit_sel == SEL_W'(i)) ? addr_pad_s[(NDIG-1-i)*4 +: 4] : addr_nib_s;
        end
    end

    // Choose between address digit and data nibble.
    always_comb begin
        nib_s = 4'h0;
        if (use_addr) begin
            nib_s = addr_nib_s;
        end else if (lo_nib) begin
            nib_s = byte_in[3:0];
        end else begin
            nib_s = byte_in[7:4];
        end
    end

    assign ascii = nib2ascii(nib_s);

endmodule

// File: rtl/mem_hex_dumper.sv
// Reads a memory range through a one-cycle-latency read port and streams
// it as ASCII hex text lines ("XX XX ..\r\n") over a valid/ready port.
// Defining DUMPER_ADDR_PREFIX_EN prefixes each line with "AAAA: ".
module mem_hex_dumper
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int BYTES_PER_LINE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    mem_hex_dumper_if.master  bus,
    output logic              busy,
    output logic              done
);

    localparam int NDIG    = (ADDR_W + 3) / 4;
    localparam int PFX_LEN = NDIG + 2;
    localparam int PI_W    = $clog2(PFX_LEN);
    localparam int RW      = ADDR_W + 1;
    localparam int LC_W    = $clog2(BYTES_PER_LINE + 1);

`ifdef DUMPER_ADDR_PREFIX_EN
    localparam state_e LINE_ST = ST_PFX;
`else
    localparam state_e LINE_ST = ST_REQ;
`endif

    state_e            state_r,     state_nx_s;
    logic [ADDR_W-1:0] cur_addr_r,  cur_addr_nx_s;
    logic [RW-1:0]     remaining_r, remaining_nx_s;
    logic [LC_W-1:0]   line_cnt_r,  line_cnt_nx_s;
    logic [PI_W-1:0]   pfx_idx_r,   pfx_idx_nx_s;
    logic [7:0]        byte_r,      byte_nx_s;

    logic              tx_valid_r;
    logic [7:0]        tx_data_r;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              busy_r;
    logic              done_r;

    logic              fire_s;
    logic              accept_s;
    logic [LC_W-1:0]   line_inc_s;
    logic [7:0]        nib_ascii_s;
    logic [7:0]        char_s;

    assign fire_s     = tx_valid_r & bus.tx_ready;
    assign accept_s   = (state_r == ST_IDLE) & start & ~busy_r;
    assign line_inc_s = line_cnt_r + LC_W'(1);

    // Next-state and datapath-next logic of the dump sequencer.
    always_comb begin
        state_nx_s     = state_r;
        cur_addr_nx_s  = cur_addr_r;
        remaining_nx_s = remaining_r;
        line_cnt_nx_s  = line_cnt_r;
        pfx_idx_nx_s   = pfx_idx_r;
        byte_nx_s      = byte_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cur_addr_nx_s  = start_addr;
                    remaining_nx_s = length;
                    line_cnt_nx_s  = {LC_W{1'b0}};
                    pfx_idx_nx_s   = {PI_W{1'b0}};
                    if (length == {RW{1'b0}}) begin
                        state_nx_s = ST_FIN;
                    end else begin
                        state_nx_s = LINE_ST;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PFX: begin
`ifdef DUMPER_ADDR_PREFIX_EN
                if (fire_s) begin
                    if (pfx_idx_r == PI_W'(PFX_LEN - 1)) begin
                        pfx_idx_nx_s = {PI_W{1'b0}};
                        state_nx_s   = ST_REQ;
                    end else begin
                        pfx_idx_nx_s = pfx_idx_r + PI_W'(1);
                    end
                end else begin
                    state_nx_s = ST_PFX;
                end
`else
                state_nx_s = ST_REQ;
`endif
            end
            ST_REQ: begin
                state_nx_s = ST_WAIT;
            end
            ST_WAIT: begin
                byte_nx_s  = bus.mem_rdata;
                state_nx_s = ST_HI;
            end
            ST_HI: begin
                if (fire_s) begin
                    state_nx_s = ST_LO;
                end else begin
                    state_nx_s = ST_HI;
                end
            end
            ST_LO: begin
                if (fire_s) begin
                    cur_addr_nx_s  = cur_addr_r + ADDR_W'(1);
                    remaining_nx_s = remaining_r - RW'(1);
                    line_cnt_nx_s  = line_inc_s;
                    if ((remaining_r == RW'(1)) || (line_inc_s == LC_W'(BYTES_PER_LINE))) begin
                        state_nx_s = ST_CR;
                    end else begin
                        state_nx_s = ST_SEP;
                    end
                end else begin
                    state_nx_s = ST_LO;
                end
            end
            ST_SEP: begin
                if (fire_s) begin
                    state_nx_s = ST_REQ;
                end else begin
                    state_nx_s = ST_SEP;
                end
            end
            ST_CR: begin
                if (fire_s) begin
                    line_cnt_nx_s = {LC_W{1'b0}};
                    state_nx_s    = ST_LF;
                end else begin
                    state_nx_s = ST_CR;
                end
            end
            ST_LF: begin
                if (fire_s) begin
                    if (remaining_r == {RW{1'b0}}) begin
                        state_nx_s = ST_FIN;
                    end else begin
                        state_nx_s = LINE_ST;
                    end
                end else begin
                    state_nx_s = ST_LF;
                end
            end
            ST_FIN: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    hex_nibble_mux #(
        .ADDR_W (ADDR_W),
        .NDIG   (NDIG),
        .SEL_W  (PI_W)
    ) u_nib (
        .byte_in   (byte_nx_s),
        .addr_in   (cur_addr_nx_s),
        .use_addr  (state_nx_s == ST_PFX),
        .digit_sel (pfx_idx_nx_s),
        .lo_nib    (state_nx_s == ST_LO),
        .ascii     (nib_ascii_s)
    );

    // Character to present in the state being entered.
    always_comb begin
        char_s = 8'h00;
        case (state_nx_s)
            ST_PFX: begin
                if (pfx_idx_nx_s < PI_W'(NDIG)) begin
                    char_s = nib_ascii_s;
                end else if (pfx_idx_nx_s == PI_W'(NDIG)) begin
                    char_s = COLON;
                end else begin
                    char_s = SP;
                end
            end
            ST_HI, ST_LO: char_s = nib_ascii_s;
            ST_SEP:       char_s = SP;
            ST_CR:        char_s = CR;
            ST_LF:        char_s = LF;
            default:      char_s = 8'h00;
        endcase
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cur_addr_r  <= {ADDR_W{1'b0}};
            remaining_r <= {RW{1'b0}};
            line_cnt_r  <= {LC_W{1'b0}};
            pfx_idx_r   <= {PI_W{1'b0}};
            byte_r      <= 8'h00;
        end else begin
            state_r     <= state_nx_s;
            cur_addr_r  <= cur_addr_nx_s;
            remaining_r <= remaining_nx_s;
            line_cnt_r  <= line_cnt_nx_s;
            pfx_idx_r   <= pfx_idx_nx_s;
            byte_r      <= byte_nx_s;
        end
    end

    // Registered outputs; stream outputs follow the state being entered so
    // tx_data stays frozen while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            mem_req_r  <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            tx_valid_r <= is_emit(state_nx_s);
            tx_data_r  <= char_s;
            mem_req_r  <= (state_nx_s == ST_REQ);
            if (state_nx_s == ST_REQ) begin
                mem_addr_r <= cur_addr_nx_s;
            end else begin
                mem_addr_r <= mem_addr_r;
            end
            done_r <= (state_r == ST_FIN);
            if (done_r) begin
                busy_r <= 1'b0;
            end else if (accept_s) begin
                busy_r <= 1'b1;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    assign bus.tx_valid = tx_valid_r;
    assign bus.tx_data  = tx_data_r;
    assign bus.mem_req  = mem_req_r;
    assign bus.mem_addr = mem_addr_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: doc/mem_hex_dumper.md
Name: mem_hex_dumper

Overview:
- Synthesizable memory reader. On command, it reads a range of the 6502 system memory through a synchronous read port and streams it as ASCII hex text over a valid/ready byte stream.
- Sits between the system memory's second read port and the UART transmitter.
- Provides the on-board readback path: memory is read out to the host as text, the inverse of preloading it from a file.

Parameters:
- ADDR_W, 16, memory address width in bits.
- BYTES_PER_LINE, 16, data bytes per text line; must be a power of two, 1..256.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe; ignored while busy=1
- start_addr  in  ADDR_W  first address to dump
- length  in  ADDR_W+1  number of bytes to dump; 0 = no data bytes
- mem_req  out  1  read strobe to memory
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  8  read data, valid exactly one cycle after mem_req
- tx_data  out  8  ASCII character
- tx_valid  out  1  character available
- tx_ready  in  1  sink accepts the character
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse when the dump completes

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal counters 0. Reset is asynchronous, so asserting rst_n mid-dump drops tx_valid, mem_req and busy immediately. No partial character is held; the FSM returns to IDLE.
- Stream handshake: a transfer occurs on a clk edge where tx_valid=1 and tx_ready=1. While tx_valid=1 and tx_ready=0, tx_data must hold stable. tx_valid never deasserts without a transfer.
- FSM states: IDLE, PFX, REQ, WAIT, HI, LO, SEP, CR, LF, FIN.
- IDLE: on start=1:
  - latch start_addr into cur_addr and length into remaining;
  - set busy=1 on the next cycle;
  - if length=0, go to FIN; else go to PFX.
- PFX: emit the line prefix (see Optional Feature), one character per transfer. Go to REQ after the last prefix character transfers, or directly to REQ when the feature is compiled out.
- REQ: mem_req=1 for exactly one cycle with mem_addr=cur_addr, then go to WAIT.
- WAIT: capture mem_rdata into a byte register, then go to HI.
- HI / LO: emit the upper nibble, then the lower nibble, as uppercase ASCII hex: 0-9 map to 0x30-0x39, A-F map to 0x41-0x46.
- After LO transfers:
  - cur_addr increments modulo 2^ADDR_W (0xFFFF wraps to 0x0000);
  - remaining decrements;
  - the line byte counter increments.
- Branch after LO:
  - if remaining=0, or the line counter reaches BYTES_PER_LINE, go to CR;
  - otherwise go to SEP.
- SEP: emit 0x20 (space), then go to REQ.
- CR / LF: emit 0x0D, then 0x0A. Clear the line counter. Then:
  - if remaining=0, go to FIN;
  - otherwise go to PFX.
- FIN: done=1 for one cycle, busy=0 on the next cycle, then go to IDLE. A start arriving in the same cycle as the done pulse is ignored.
- Throughput: one memory read per 3+ characters; no read is issued while a character is pending.
- mem_addr holds its last value outside REQ and is 0 after reset.
- length is 17 bits, so a full 65536-byte dump is expressible; remaining uses ADDR_W+1 bits.

Optional Feature:
- Macro: DUMPER_ADDR_PREFIX_EN.
- Defined: every line begins with the line's first address, 4 uppercase hex digits (for ADDR_W=16), followed by ':' (0x3A) and ' ' (0x20). The address is cur_addr at line start, including after a wrap.
- Undefined: PFX is skipped entirely; lines contain only data bytes and separators.

Decomposition:
- Shared package mem_dump_pkg holds:
  - the FSM state enum type;
  - ASCII constants: SP=0x20, CR=0x0D, LF=0x0A, COLON=0x3A;
  - function nib2ascii(4-bit) returning 8 bits.
- One natural sub-module: hex_nibble_mux, which selects the nibble from the byte register or the prefix address and converts it to ASCII. The FSM stays in mem_hex_dumper.

Test Plan:
- Bytes 0x00,0xAB,0x7F at 0x0200 with tx_ready=1, prefix off, start_addr=0x0200, length=3 -> stream "00 AB 7F\r\n"; done pulses once; exactly 3 mem_req pulses at 0x0200..0x0202.
- Prefix on, BYTES_PER_LINE=16, start_addr=0x0010, length=17 -> "0010: " + 16 bytes + CRLF, then "0020: " + 1 byte + CRLF.
- start_addr=0xFFFF, length=2 -> reads 0xFFFF then 0x0000; with prefix on, the line prefix is "FFFF: ".
- length=0 -> no tx_valid, no mem_req; done pulses 2 cycles after start.
- tx_ready randomly low 50% -> tx_data stable while stalled; output identical to the tx_ready=1 run.
- rst_n asserted low after 5 characters of a 16-byte dump -> tx_valid, busy and mem_req go 0 immediately. After release, a new start with length=1 produces a complete line from IDLE.
